// File: rtl/sr_deser_if.sv
// Bus bundle for sr_deser: serial bit input side and buffered word output side.
interface sr_deser_if;
    logic       serial_in;
    logic       bit_valid;
    logic       resync;
    logic       word_ready;
    logic [9:0] word_out;
    logic       is_comma;
    logic       word_valid;
    logic       locked;
    logic       align_err;
    logic       overflow;
    logic [2:0] fifo_count;

    // Producer of serial bits and consumer of words
    modport master (
        output serial_in, bit_valid, resync, word_ready,
        input  word_out, is_comma, word_valid, locked, align_err, overflow, fifo_count
    );

    // The deserializer itself
    modport slave (
        input  serial_in, bit_valid, resync, word_ready,
        output word_out, is_comma, word_valid, locked, align_err, overflow, fifo_count
    );
endinterface

// File: rtl/sr_deser.sv
// Serial-to-10-bit deserializer with comma alignment (HUNT/SYNC) and a small
// output word FIFO. Words are MSB-first; first received bit lands in word_out[9].
module sr_deser #(
    parameter logic [9:0]  COMMA_P    = 10'b0011111010,
    parameter logic [9:0]  COMMA_N    = 10'b1100000101,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic       clk,
    input logic       n_rst,
    sr_deser_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] SYNC = 1'b1;

    logic [0:0]    state;
    // Only the nine most recent bits are kept; the tenth bit of every
    // candidate word is the incoming serial_in itself.
    logic [8:0]    sr;
    logic [3:0]    bit_cnt;
    logic [9:0]    cand;
    logic          match;
    logic          accept;
    logic          push;
    logic          push_comma;
    logic          realign;
    logic          align_err_q;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          drop;
    logic [10:0]   head;

    // Candidate word, comma detection and push decision for the current bit
    always_comb begin
        accept     = bus.bit_valid && !bus.resync;
        cand       = {sr, bus.serial_in};
        match      = (cand == COMMA_P) || (cand == COMMA_N);
        push       = 1'b0;
        push_comma = 1'b0;
        realign    = 1'b0;
        if (accept) begin
            if (state == HUNT) begin
                if (match) begin
                    push       = 1'b1;
                    push_comma = 1'b1;
                end
            end else if (bit_cnt == 4'd9) begin
                push       = 1'b1;
                push_comma = match;
            end else if (match) begin
                push       = 1'b1;
                push_comma = 1'b1;
                realign    = 1'b1;
            end
        end
    end

    // Alignment state machine, shift register and bit counter
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state       <= HUNT;
            sr          <= '0;
            bit_cnt     <= '0;
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= realign;
            if (bus.resync) begin
                state   <= HUNT;
                sr      <= '0;
                bit_cnt <= '0;
            end else if (bus.bit_valid) begin
                sr <= cand[8:0];
                if (state == HUNT) begin
                    if (match) begin
                        state   <= SYNC;
                        bit_cnt <= '0;
                    end
                end else if (push) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so push-while-full
    // only drops when the head is not being consumed.
    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        pop     = !empty && bus.word_ready;
        do_push = push && (!full || pop);
        drop    = push && full && !pop;
        head    = mem[rd_ptr];
    end

    // FIFO storage, no reset needed since the output is gated by empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_comma, cand};
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign bus.word_out   = empty ? '0 : head[9:0];
    assign bus.is_comma   = !empty && head[10];
    assign bus.word_valid = !empty;
    assign bus.locked     = (state == SYNC);
    assign bus.align_err  = align_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = 3'(count);
endmodule

// File: tb/tb_sr_deser.sv
// Directed bench for sr_deser: reset, lock, gapped input, realign, overflow, resync.
module tb_sr_deser;
    logic clk = 1'b0;
    logic n_rst;
    int   vectors = 0;
    int   errors  = 0;

    sr_deser_if bus ();

    sr_deser #(
        .COMMA_P   (10'b0011111010),
        .COMMA_N   (10'b1100000101),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.bit_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        bus.bit_valid = 1'b1;
        @(negedge clk);
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic apply_reset();
        n_rst          = 1'b1;
        bus.bit_valid  = 1'b0;
        bus.resync     = 1'b0;
        bus.word_ready = 1'b0;
        bus.serial_in  = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (bus.word_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL init_reset valid=%b count=%0d locked=%b required 0/0/0",
                     bus.word_valid, bus.fifo_count, bus.locked);
        end
        // Lock and buffer a word, then reset mid-stream with resync also asserted
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(10'h0FA);
        vectors++;
        if (bus.locked !== 1'b1 || bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL pre_reset locked=%b count=%0d required 1/1", bus.locked, bus.fifo_count);
        end
        n_rst         = 1'b1;
        bus.resync    = 1'b1;
        bus.bit_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.serial_in = ~bus.serial_in;
            @(negedge clk);
        end
        n_rst         = 1'b0;
        bus.resync    = 1'b0;
        bus.bit_valid = 1'b0;
        vectors++;
        if (bus.word_out !== 10'h000) begin
            errors++; $display("FAIL rst_word_out got=%h required=000", bus.word_out);
        end
        vectors++;
        if (bus.is_comma !== 1'b0) begin
            errors++; $display("FAIL rst_is_comma got=%b required=0", bus.is_comma);
        end
        vectors++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL rst_word_valid got=%b required=0", bus.word_valid);
        end
        vectors++;
        if (bus.locked !== 1'b0) begin
            errors++; $display("FAIL rst_locked got=%b required=0", bus.locked);
        end
        vectors++;
        if (bus.align_err !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL rst_pulses align_err=%b overflow=%b required 0/0",
                               bus.align_err, bus.overflow);
        end
        vectors++;
        if (bus.fifo_count !== 3'd0) begin
            errors++; $display("FAIL rst_fifo_count got=%0d required=0", bus.fifo_count);
        end
    endtask

    // Prefix 1,0,1 then comma 0x0FA then data 0x2AA, optionally with an idle before every bit
    task automatic lock_stream(input bit gap, input string tag);
        logic [9:0] w;
        apply_reset();
        bus.word_ready = 1'b1;
        w = 10'b0000000101;
        for (int i = 2; i >= 0; i--) begin
            if (gap) idle();
            send_bit(w[i]);
        end
        w = 10'h0FA;
        for (int i = 9; i >= 0; i--) begin
            if (gap) idle();
            send_bit(w[i]);
            if (i > 0) begin
                vectors++;
                if (bus.locked !== 1'b0 || bus.word_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_lock bit=%0d locked=%b valid=%b required 0/0",
                             tag, i, bus.locked, bus.word_valid);
                end
            end
        end
        vectors++;
        if (bus.locked !== 1'b1 || bus.word_valid !== 1'b1 || bus.word_out !== 10'h0FA
            || bus.is_comma !== 1'b1) begin
            errors++;
            $display("FAIL %s comma_word locked=%b valid=%b word=%h comma=%b required 1/1/0fa/1",
                     tag, bus.locked, bus.word_valid, bus.word_out, bus.is_comma);
        end
        w = 10'h2AA;
        for (int i = 9; i >= 0; i--) begin
            if (gap) idle();
            send_bit(w[i]);
            if (i > 0) begin
                vectors++;
                if (bus.word_valid !== 1'b0 || bus.locked !== 1'b1) begin
                    errors++;
                    $display("FAIL %s data_gap bit=%0d valid=%b locked=%b required 0/1",
                             tag, i, bus.word_valid, bus.locked);
                end
            end
        end
        vectors++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 10'h2AA || bus.is_comma !== 1'b0
            || bus.align_err !== 1'b0) begin
            errors++;
            $display("FAIL %s data_word valid=%b word=%h comma=%b aerr=%b required 1/2aa/0/0",
                     tag, bus.word_valid, bus.word_out, bus.is_comma, bus.align_err);
        end
        idle();
        vectors++;
        if (bus.word_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL %s drained valid=%b count=%0d required 0/0", tag, bus.word_valid, bus.fifo_count);
        end
    endtask

    task automatic test_lock();
        lock_stream(1'b0, "lock");
    endtask

    task automatic test_gapped();
        lock_stream(1'b1, "gapped");
    endtask

    // Continues from a locked, word-aligned state with word_ready=1
    task automatic test_realign();
        logic [9:0] w;
        w = 10'b0000000110;
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
        w = 10'h305;
        for (int i = 9; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == 4) begin
                vectors++;
                if (bus.word_valid !== 1'b1 || bus.word_out !== 10'h1B0 || bus.is_comma !== 1'b0
                    || bus.align_err !== 1'b0) begin
                    errors++;
                    $display("FAIL realign_boundary valid=%b word=%h comma=%b aerr=%b required 1/1b0/0/0",
                             bus.word_valid, bus.word_out, bus.is_comma, bus.align_err);
                end
            end
        end
        vectors++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 10'h305 || bus.is_comma !== 1'b1
            || bus.align_err !== 1'b1 || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL realign_comma valid=%b word=%h comma=%b aerr=%b locked=%b required 1/305/1/1/1",
                     bus.word_valid, bus.word_out, bus.is_comma, bus.align_err, bus.locked);
        end
        w = 10'h155;
        for (int i = 9; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == 9) begin
                vectors++;
                if (bus.align_err !== 1'b0) begin
                    errors++; $display("FAIL realign_pulse_len aerr=%b required=0", bus.align_err);
                end
            end
        end
        vectors++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 10'h155 || bus.is_comma !== 1'b0) begin
            errors++;
            $display("FAIL realign_next valid=%b word=%h comma=%b required 1/155/0",
                     bus.word_valid, bus.word_out, bus.is_comma);
        end
        idle();
    endtask

    task automatic test_overflow();
        logic [9:0] wl [5];
        logic [9:0] exp_q [4];
        logic [9:0] w;
        wl[0] = 10'h2AA; wl[1] = 10'h155; wl[2] = 10'h2B5; wl[3] = 10'h14A; wl[4] = 10'h299;
        exp_q[0] = 10'h155; exp_q[1] = 10'h2B5; exp_q[2] = 10'h14A; exp_q[3] = 10'h0A5;
        apply_reset();
        bus.word_ready = 1'b1;
        send_word(10'h0FA);
        idle();
        bus.word_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_word(wl[k]);
            vectors++;
            if (bus.fifo_count !== ((k < 4) ? 3'(k + 1) : 3'd4) || bus.overflow !== (k == 4)) begin
                errors++;
                $display("FAIL ovf_fill word=%0d count=%0d ovf=%b required %0d/%b",
                         k, bus.fifo_count, bus.overflow, (k < 4) ? k + 1 : 4, (k == 4));
            end
        end
        idle();
        vectors++;
        if (bus.overflow !== 1'b0 || bus.fifo_count !== 3'd4 || bus.word_out !== 10'h2AA) begin
            errors++;
            $display("FAIL ovf_hold ovf=%b count=%0d head=%h required 0/4/2aa",
                     bus.overflow, bus.fifo_count, bus.word_out);
        end
        // Push and pop in the same cycle while full
        w = 10'h0A5;
        for (int i = 9; i >= 1; i--) send_bit(w[i]);
        bus.word_ready = 1'b1;
        send_bit(w[0]);
        bus.word_ready = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0 || bus.fifo_count !== 3'd4 || bus.word_out !== 10'h155) begin
            errors++;
            $display("FAIL ovf_push_pop ovf=%b count=%0d head=%h required 0/4/155",
                     bus.overflow, bus.fifo_count, bus.word_out);
        end
        bus.word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.word_valid !== 1'b1 || bus.word_out !== exp_q[k]) begin
                errors++;
                $display("FAIL ovf_drain idx=%0d valid=%b word=%h required 1/%h",
                         k, bus.word_valid, bus.word_out, exp_q[k]);
            end
            @(negedge clk);
        end
        vectors++;
        if (bus.word_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ovf_empty valid=%b count=%0d required 0/0", bus.word_valid, bus.fifo_count);
        end
        @(negedge clk);
        vectors++;
        if (bus.fifo_count !== 3'd0) begin
            errors++; $display("FAIL pop_on_empty count=%0d required=0", bus.fifo_count);
        end
        bus.word_ready = 1'b0;
    endtask

    task automatic test_resync();
        logic [9:0] w;
        apply_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_word(10'h0FA);
        send_word(10'h2AA);
        w = 10'h155;
        for (int i = 9; i >= 4; i--) send_bit(w[i]);
        bus.resync    = 1'b1;
        bus.bit_valid = 1'b1;
        bus.serial_in = 1'b0;
        @(negedge clk);
        bus.resync    = 1'b0;
        bus.bit_valid = 1'b0;
        vectors++;
        if (bus.locked !== 1'b0 || bus.fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL resync_now locked=%b count=%0d required 0/2", bus.locked, bus.fifo_count);
        end
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
        vectors++;
        if (bus.locked !== 1'b0 || bus.fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL resync_tail locked=%b count=%0d required 0/2", bus.locked, bus.fifo_count);
        end
        bus.word_ready = 1'b1;
        vectors++;
        if (bus.word_out !== 10'h0FA || bus.is_comma !== 1'b1) begin
            errors++;
            $display("FAIL resync_drain0 word=%h comma=%b required 0fa/1", bus.word_out, bus.is_comma);
        end
        @(negedge clk);
        vectors++;
        if (bus.word_out !== 10'h2AA || bus.is_comma !== 1'b0 || bus.word_valid !== 1'b1) begin
            errors++;
            $display("FAIL resync_drain1 word=%h comma=%b valid=%b required 2aa/0/1",
                     bus.word_out, bus.is_comma, bus.word_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL resync_empty valid=%b required=0", bus.word_valid);
        end
        bus.word_ready = 1'b0;
    endtask

    initial begin
        n_rst          = 1'b1;
        bus.serial_in  = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.resync     = 1'b0;
        bus.word_ready = 1'b0;
        test_reset();
        test_lock();
        test_gapped();
        test_realign();
        test_overflow();
        test_resync();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sr_deser.md
SR_DESER -- requirements
Module: sr_deser

Interface
REQ-001 Parameter COMMA_P, default 10'b0011111010 (0x0FA), positive-disparity alignment pattern.
REQ-002 Parameter COMMA_N, default 10'b1100000101 (0x305), negative-disparity alignment pattern.
REQ-003 Parameter FIFO_DEPTH, default 4, output word buffer depth (power of two, >=2).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 n_rst  in  1  reset, synchronous, active-high.
REQ-006 serial_in  in  1  serial bit stream from the ping-pong shift stage, MSB of each word first.
REQ-007 bit_valid  in  1  qualifies serial_in; a bit is accepted only in cycles with bit_valid=1.
REQ-008 resync  in  1  forces return to hunt, discards partial word.
REQ-009 word_out  out  10  head-of-buffer word; first received bit in word_out[9].
REQ-010 is_comma  out  1  head word matched COMMA_P or COMMA_N.
REQ-011 word_valid  out  1  buffer non-empty.
REQ-012 word_ready  in  1  consumer accepts head word when word_valid=1.
REQ-013 locked  out  1  high while in SYNC state.
REQ-014 align_err  out  1  one-cycle pulse on off-boundary comma in SYNC.
REQ-015 overflow  out  1  one-cycle pulse when a completed word is dropped.
REQ-016 fifo_count  out  3  number of buffered words, 0..FIFO_DEPTH.

Function
REQ-017 Shift register sr[9:0] SHALL update to {sr[8:0], serial_in} on every accepted bit; candidate word cand = {sr[8:0], serial_in}.
REQ-018 Comma match SHALL be cand==COMMA_P or cand==COMMA_N, evaluated only on accepted bits.
REQ-019 States SHALL be HUNT and SYNC only; locked = (state==SYNC).
REQ-020 HUNT: on accepted bit with comma match -> SYNC, bit_cnt<=0, push cand with is_comma=1; non-matching bits push nothing.
REQ-021 SYNC: bit_cnt SHALL count accepted bits 0..9; accepted bit with bit_cnt==9 -> push cand (is_comma per match), bit_cnt<=0.
REQ-022 SYNC: accepted bit with comma match and bit_cnt!=9 -> align_err pulse next cycle, push cand with is_comma=1, bit_cnt<=0, stay SYNC.
REQ-023 Cycles with bit_valid=0 SHALL leave sr, bit_cnt and state unchanged.
REQ-024 resync=1 SHALL take priority over any accepted bit: state<=HUNT, bit_cnt<=0, sr<=0, no push; buffer contents retained.
REQ-025 Pushed word SHALL appear on word_out/word_valid the cycle after the accepting edge when buffer was empty (latency 1).
REQ-026 Pop SHALL occur when word_valid && word_ready; order strictly FIFO.
REQ-027 Push with buffer full and no pop: word dropped, overflow pulse next cycle, contents and fifo_count unchanged.
REQ-028 Push and pop same cycle when full SHALL both succeed, fifo_count unchanged, no overflow.
REQ-029 Push and pop same cycle when non-empty SHALL leave fifo_count unchanged; pop on empty SHALL be ignored.
REQ-030 Buffer pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 n_rst=1 at a clock edge SHALL set state=HUNT, sr=0, bit_cnt=0, buffer empty; word_out=0, is_comma=0, word_valid=0, locked=0, align_err=0, overflow=0, fifo_count=0.
REQ-032 Reset mid-word or mid-handshake SHALL discard partial and buffered words; n_rst overrides resync and bit_valid.

Verification
REQ-033 Reset: n_rst=1 for 2 cycles during an active stream -> all outputs 0 next cycle, locked=0.
REQ-034 Lock: bits 1,0,1 then 0x0FA then 0x2AA MSB-first, bit_valid=1, word_ready=1 -> locked=1 after comma's 10th bit, word_out=0x0FA is_comma=1, then 0x2AA is_comma=0.
REQ-035 Gapped input: same stream with bit_valid toggling 1,0 -> identical words, each one cycle after its 10th accepted bit.
REQ-036 Realign: locked, 4 data bits then 0x305 -> align_err one pulse, word 0x305 is_comma=1, next 10 bits emitted as one word.
REQ-037 Overflow: word_ready=0, 5 words after lock -> fifo_count=4, overflow pulse on 5th, first 4 words drain in order when word_ready=1.
REQ-038 Resync: resync=1 after 6 bits of a word -> locked=0 next cycle, no word pushed, buffered words still drain.
